// File: rtl/multicycle_controller.sv
// multicycle_controller: DECODE/EXEC/MEM/WB control FSM for the single-ALU datapath.
// Define PERF_CNT_EN to add the retired-instruction counter port.
module multicycle_controller #(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [5:0]       Opcode,
  input  logic             Zero,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             branch_taken,
  output logic             illegal,
`ifdef PERF_CNT_EN
  output logic [CNT_W-1:0] retired,
`endif
  output logic             busy
);
  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000;
  state_t state, nxt;
  logic [5:0] opc;
  logic [3:0] cnt;
  logic is_r, is_lw, is_sw, is_beq, is_addi, legal, last;
  assign is_r        = opc == OP_R;
  assign is_lw       = opc == OP_LW;
  assign is_sw       = opc == OP_SW;
  assign is_beq      = opc == OP_BEQ;
  assign is_addi     = opc == OP_ADDI;
  assign legal       = is_r || is_lw || is_sw || is_beq || is_addi;
  assign last        = cnt == 4'd0;
  assign instr_ready = state == IDLE;
  assign busy        = state != IDLE;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      opc   <= '0;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (instr_valid && instr_ready) opc <= Opcode;
      if (state == EXEC) cnt <= 4'(MEM_WAIT);
      else if (state == MEM && !last) cnt <= cnt - 4'd1;
    end
  end
`ifdef PERF_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) retired <= '0;
    else if (state == WB || (state == MEM && is_sw && last) || (state == EXEC && is_beq))
      retired <= retired + 1'b1;
  end
`endif
  always_comb begin
    nxt          = state;
    RegDst       = 1'b0;
    ALUSrc       = 1'b0;
    ALUOp        = 2'b00;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    MemToReg     = 1'b0;
    RegWrite     = 1'b0;
    branch_taken = 1'b0;
    illegal      = 1'b0;
    case (state)
      IDLE: nxt = instr_valid ? DECODE : IDLE;
      DECODE: begin
        illegal = !legal;
        nxt     = legal ? EXEC : IDLE;
      end
      EXEC: begin
        ALUSrc       = !(is_r || is_beq);
        ALUOp        = is_r ? 2'b10 : is_beq ? 2'b01 : 2'b00;
        branch_taken = is_beq && Zero;
        nxt          = is_beq ? IDLE : (is_lw || is_sw) ? MEM : WB;
      end
      MEM: begin
        ALUSrc   = 1'b1;
        MemRead  = is_lw;
        MemToReg = is_lw;
        MemWrite = is_sw && last;
        nxt      = !last ? MEM : is_lw ? WB : IDLE;
      end
      WB: begin
        RegWrite = 1'b1;
        RegDst   = is_r;
        ALUOp    = is_r ? 2'b10 : 2'b00;
        ALUSrc   = is_addi;
        MemToReg = is_lw;
        MemRead  = is_lw;
        nxt      = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized bench against a per-opcode timeline model.
module tb_multicycle_controller;
  localparam int MW = 2;
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, ADDI = 6'b001000;
  logic clock = 0, reset_n = 0, instr_valid = 0, Zero = 0;
  logic [5:0] Opcode = 0;
  logic instr_ready, RegDst, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite, branch_taken, illegal, busy;
  logic [1:0] ALUOp;
`ifdef PERF_CNT_EN
  logic [15:0] retired;
`endif
  logic [9:0] obs;
  int total = 0, bad = 0, ret_m = 0;
  multicycle_controller #(.MEM_WAIT(MW), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .Opcode(Opcode), .Zero(Zero), .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .branch_taken(branch_taken), .illegal(illegal),
`ifdef PERF_CNT_EN
    .retired(retired),
`endif
    .busy(busy));
  always #5 clock = ~clock;
  assign obs = {RegDst, ALUSrc, ALUOp, MemRead, MemWrite, MemToReg, RegWrite, branch_taken, illegal};
  function automatic bit is_legal(logic [5:0] op);
    return op == R || op == LW || op == SW || op == BEQ || op == ADDI;
  endfunction
  function automatic int lat_of(logic [5:0] op);
    if (!is_legal(op)) return 1;
    if (op == BEQ) return 2;
    if (op == LW) return 4 + MW;
    if (op == SW) return 3 + MW;
    return 3;
  endfunction
  // Cycle k counts from the first cycle after the handshake edge; bit order matches obs.
  function automatic logic [9:0] exp_out(logic [5:0] op, int k, logic z);
    if (!is_legal(op)) return (k == 0) ? 10'b00_0000_0001 : 10'b0;
    if (k == 1) begin
      if (op == R) return {1'b0, 1'b0, 2'b10, 6'b0};
      if (op == BEQ) return {1'b0, 1'b0, 2'b01, 4'b0, z, 1'b0};
      return {1'b0, 1'b1, 2'b00, 6'b0};
    end
    if ((op == LW || op == SW) && k >= 2 && k <= 2 + MW)
      return (op == LW) ? {1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 3'b0}
                        : {1'b0, 1'b1, 2'b00, 1'b0, 1'(k == 2 + MW), 4'b0};
    if (op == R && k == 2) return {1'b1, 1'b0, 2'b10, 3'b0, 1'b1, 2'b0};
    if (op == ADDI && k == 2) return {1'b0, 1'b1, 2'b00, 3'b0, 1'b1, 2'b0};
    if (op == LW && k == 3 + MW) return {1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 2'b0};
    return 10'b0;
  endfunction
  task automatic check_idle(input string name);
    total++;
    if (obs !== 10'b0 || busy !== 1'b0 || instr_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s: got out=%b busy=%b ready=%b, want out=0 busy=0 ready=1", name, obs, busy, instr_ready);
    end
`ifdef PERF_CNT_EN
    total++;
    if (retired !== 16'(ret_m)) begin
      bad++;
      $display("FAIL %s retired: got %0d want %0d", name, retired, ret_m);
    end
`endif
  endtask
  // Called just after the handshake edge; ends on a negedge with the controller idle.
  task automatic run_checks(input logic [5:0] op, input int zs, input string name);
    int lat;
    logic z;
    logic [9:0] ev;
    lat = lat_of(op);
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) begin
        @(posedge clock);
        #1;
      end
      z = (zs == 2) ? 1'($urandom_range(0, 1)) : 1'(zs);
      Zero = z;
      @(negedge clock);
      if (k == lat) begin
        if (is_legal(op)) ret_m++;
        check_idle(name);
      end else begin
        ev = exp_out(op, k, z);
        total++;
        if (obs !== ev || busy !== 1'b1 || instr_ready !== 1'b0 || (MemWrite && RegWrite)) begin
          bad++;
          $display("FAIL %s op=%b k=%0d: got out=%b busy=%b ready=%b, want out=%b busy=1 ready=0",
                   name, op, k, obs, busy, instr_ready, ev);
        end
      end
    end
  endtask
  task automatic issue(input logic [5:0] op, input int zs, input string name);
    instr_valid = 1;
    Opcode = op;
    @(posedge clock);
    #1;
    instr_valid = 0;
    Opcode = 6'($urandom);
    run_checks(op, zs, name);
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clock);
    check_idle("reset_state");
    reset_n = 1;
  endtask
  task automatic test_reset_mid;
    instr_valid = 1;
    Opcode = R;
    @(posedge clock);
    #1;
    instr_valid = 0;
    @(posedge clock);
    #1;
    reset_n = 0;
    ret_m = 0;
    #1;
    check_idle("reset_in_exec");
    @(negedge clock);
    reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      total++;
      if (RegWrite !== 1'b0 || instr_ready !== 1'b1) begin
        bad++;
        $display("FAIL after_reset cyc=%0d: got RegWrite=%b ready=%b, want RegWrite=0 ready=1", i, RegWrite, instr_ready);
      end
    end
  endtask
  task automatic test_types;
    issue(R, 2, "r_type");
    issue(LW, 2, "lw");
    issue(SW, 2, "sw");
    issue(ADDI, 2, "addi");
    issue(BEQ, 1, "beq_taken");
    issue(BEQ, 0, "beq_not_taken");
  endtask
  task automatic test_back_to_back;
    instr_valid = 1;
    Opcode = 6'b111111;
    @(posedge clock);
    #1;
    Opcode = R;
    @(negedge clock);
    total++;
    if (obs !== 10'b00_0000_0001 || busy !== 1'b1) begin
      bad++;
      $display("FAIL illegal_pulse: got out=%b busy=%b, want out=0000000001 busy=1", obs, busy);
    end
    @(negedge clock);
    check_idle("illegal_return");
    @(posedge clock);
    #1;
    instr_valid = 0;
    run_checks(R, 2, "b2b_r_type");
  endtask
  task automatic test_random;
    logic [5:0] op;
    logic [5:0] ops [5];
    ops = '{R, LW, SW, BEQ, ADDI};
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 4)];
      issue(op, 2, "random");
    end
  endtask
  initial begin
    test_reset;
    test_types;
    test_back_to_back;
    test_random;
    test_reset_mid;
    issue(LW, 2, "lw_after_reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
